// File: rtl/alu_cmd_issuer.sv
// Issue/return stage for the 1-cycle inc/dec ALU: queues commands, issues them under result-FIFO credit,
// and returns tagged results in order. Accept-to-result latency is 3 cycles; the ALU itself never stalls.
module alu_cmd_issuer #(
  parameter int CMD_DEPTH = 8,
  parameter int RES_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_cmd,
  input  logic [7:0] in_addr,
  input  logic [7:0] in_data,
  output logic       alu_cmd,
  output logic [7:0] alu_addr,
  output logic [7:0] alu_data,
  input  logic [7:0] alu_dout,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       res_cmd,
  output logic [7:0] res_addr,
  output logic [7:0] res_data
);

  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int RAW = $clog2(RES_DEPTH);

  typedef struct packed {
    logic       cmd;
    logic [7:0] addr;
    logic [7:0] data;
  } txn_t;

  txn_t           cmd_mem_q [CMD_DEPTH];
  logic [CAW-1:0] cmd_wr_q, cmd_rd_q;
  logic [CAW:0]   cmd_cnt_q, cmd_cnt_d;
  txn_t           res_mem_q [RES_DEPTH];
  logic [RAW-1:0] res_wr_q, res_rd_q;
  logic [RAW:0]   res_cnt_q, res_cnt_d;
  logic           s1_q, s2_q, s2_cmd_q;
  logic [7:0]     s2_addr_q;

  logic           cmd_push, issue, res_push, res_pop;
  logic [RAW+1:0] credits_used;
  txn_t           cmd_head, res_head;

  always_comb begin
    in_ready  = (cmd_cnt_q != (CAW+1)'(CMD_DEPTH));
    cmd_push  = in_valid && in_ready;
    // Credits come back only from registered occupancy, so a pop never races an issue combinationally.
    credits_used = (RAW+2)'(s1_q) + (RAW+2)'(s2_q) + (RAW+2)'(res_cnt_q);
    issue     = (cmd_cnt_q != '0) && (credits_used < (RAW+2)'(RES_DEPTH));
    res_push  = s2_q;
    res_valid = (res_cnt_q != '0);
    res_pop   = res_valid && res_ready;
    cmd_cnt_d = cmd_cnt_q + (CAW+1)'(cmd_push) - (CAW+1)'(issue);
    res_cnt_d = res_cnt_q + (RAW+1)'(res_push) - (RAW+1)'(res_pop);
    cmd_head  = cmd_mem_q[cmd_rd_q];
    res_head  = res_mem_q[res_rd_q];
    // Gate with valid so stale storage never leaks out after a flush.
    res_cmd   = res_valid ? res_head.cmd  : 1'b0;
    res_addr  = res_valid ? res_head.addr : 8'h00;
    res_data  = res_valid ? res_head.data : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cmd_wr_q  <= '0;
      cmd_rd_q  <= '0;
      cmd_cnt_q <= '0;
      res_wr_q  <= '0;
      res_rd_q  <= '0;
      res_cnt_q <= '0;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s2_cmd_q  <= 1'b0;
      s2_addr_q <= 8'h00;
      alu_cmd   <= 1'b0;
      alu_addr  <= 8'h00;
      alu_data  <= 8'h00;
    end else begin
      cmd_cnt_q <= cmd_cnt_d;
      res_cnt_q <= res_cnt_d;
      if (cmd_push) cmd_wr_q <= cmd_wr_q + CAW'(1);
      if (issue) begin
        cmd_rd_q <= cmd_rd_q + CAW'(1);
        alu_cmd  <= cmd_head.cmd;
        alu_addr <= cmd_head.addr;
        alu_data <= cmd_head.data;
      end
      // alu_cmd/alu_addr double as the stage-1 tag; they only move on issue.
      s1_q      <= issue;
      s2_q      <= s1_q;
      s2_cmd_q  <= alu_cmd;
      s2_addr_q <= alu_addr;
      if (res_push) res_wr_q <= res_wr_q + RAW'(1);
      if (res_pop)  res_rd_q <= res_rd_q + RAW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem_q[cmd_wr_q] <= {in_cmd, in_addr, in_data};
    if (res_push) res_mem_q[res_wr_q] <= {s2_cmd_q, s2_addr_q, alu_dout};
  end

  a_no_res_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(res_push && !res_pop && res_cnt_q == (RAW+1)'(RES_DEPTH)));

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed and random checks of alu_cmd_issuer against a behavioural inc/dec ALU and an in-order scoreboard.
module tb_alu_cmd_issuer;

  logic       clk, rst;
  logic       in_valid, in_ready, in_cmd;
  logic [7:0] in_addr, in_data;
  logic       alu_cmd;
  logic [7:0] alu_addr, alu_data, alu_dout;
  logic       res_valid, res_ready, res_cmd;
  logic [7:0] res_addr, res_data;

  alu_cmd_issuer #(.CMD_DEPTH(8), .RES_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd), .in_addr(in_addr), .in_data(in_data),
    .alu_cmd(alu_cmd), .alu_addr(alu_addr), .alu_data(alu_data), .alu_dout(alu_dout),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_cmd(res_cmd), .res_addr(res_addr), .res_data(res_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU stage sharing the same reset.
  always_ff @(posedge clk) begin
    if (!rst) alu_dout <= 8'h00;
    else      alu_dout <= alu_cmd ? alu_data - 8'd1 : alu_data + 8'd1;
  end

  typedef struct {
    logic       cmd;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  vec_t        vecs [6];
  logic [16:0] exp_q [$];
  int          checks = 0;
  int          failures = 0;
  int          n_tx = 0;
  int          n_rx = 0;
  int          cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] alu_ref(input logic c, input logic [7:0] d);
    return c ? d - 8'd1 : d + 8'd1;
  endfunction

  // One clock: scoreboard the handshakes seen just before the edge, then step to #1 after it.
  task automatic cycle();
    logic [16:0] e;
    @(negedge clk);
    if (rst) begin
      if (res_valid && res_ready) begin
        chk("sb_has_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("sb_result", 32'({res_cmd, res_addr, res_data}), 32'(e));
          n_rx++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({in_cmd, in_addr, alu_ref(in_cmd, in_data)});
        n_tx++;
      end
    end else begin
      exp_q.delete();
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic latency_op(input string tag, input logic c, input logic [7:0] a,
                            input logic [7:0] d, input logic [7:0] x);
    in_valid = 1'b1; in_cmd = c; in_addr = a; in_data = d; res_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    chk({tag, "_e1_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_e1_alu_data"}, 32'(alu_data), 32'(d));
    cycle();
    chk({tag, "_e2_valid"}, 32'(res_valid), 32'd0);
    cycle();
    chk({tag, "_e3_valid"}, 32'(res_valid), 32'd1);
    chk({tag, "_e3_data"}, 32'(res_data), 32'(x));
    chk({tag, "_e3_addr"}, 32'(res_addr), 32'(a));
    chk({tag, "_e3_cmd"}, 32'(res_cmd), 32'(c));
    cycle();
    chk({tag, "_e4_valid"}, 32'(res_valid), 32'd0);
  endtask

  initial begin
    int   acc_cnt, issued, first, last, nres, start_tx, start_rx, max_res;
    bit   acc, ir_drop, seen;
    logic [7:0] prev_addr;

    vecs[0] = '{cmd: 1'b0, addr: 8'h10, data: 8'h41, exp: 8'h42};
    vecs[1] = '{cmd: 1'b1, addr: 8'h01, data: 8'h00, exp: 8'hFF};
    vecs[2] = '{cmd: 1'b0, addr: 8'h02, data: 8'hFF, exp: 8'h00};
    vecs[3] = '{cmd: 1'b1, addr: 8'h33, data: 8'h80, exp: 8'h7F};
    vecs[4] = '{cmd: 1'b0, addr: 8'h44, data: 8'h7F, exp: 8'h80};
    vecs[5] = '{cmd: 1'b1, addr: 8'h55, data: 8'h01, exp: 8'h00};

    rst = 1'b0; in_valid = 1'b0; in_cmd = 1'b0; in_addr = 8'h00; in_data = 8'h00; res_ready = 1'b1;
    cycle();
    cycle();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_fields", 32'({res_cmd, res_addr, res_data}), 32'd0);
    chk("rst_alu_regs", 32'({alu_cmd, alu_addr, alu_data}), 32'd0);
    rst = 1'b1;
    cycle();

    for (int v = 0; v < 6; v++)
      latency_op($sformatf("vec%0d", v), vecs[v].cmd, vecs[v].addr, vecs[v].data, vecs[v].exp);

    // Backpressure: results stalled, 14 offered, only credits + command FIFO get in.
    res_ready = 1'b0; acc_cnt = 0; issued = 0; prev_addr = alu_addr;
    in_valid = 1'b1; in_cmd = 1'b0; in_addr = 8'h80; in_data = 8'h20;
    start_rx = n_rx;
    for (int c = 0; c < 30; c++) begin
      acc = in_valid && in_ready;
      cycle();
      if (alu_addr != prev_addr) issued++;
      prev_addr = alu_addr;
      if (acc) begin
        acc_cnt++;
        if (acc_cnt == 14) in_valid = 1'b0;
        in_cmd = acc_cnt[0]; in_addr = 8'h80 + 8'(acc_cnt); in_data = 8'h20 + 8'(acc_cnt * 3);
      end
    end
    chk("bp_accepted", 32'(acc_cnt), 32'd12);
    chk("bp_issued", 32'(issued), 32'd4);
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    chk("bp_res_valid", 32'(res_valid), 32'd1);
    in_valid = 1'b0; res_ready = 1'b1;
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) cycle();
    chk("bp_drained", 32'(exp_q.size()), 32'd0);
    chk("bp_returned", 32'(n_rx - start_rx), 32'd12);
    cycle(); cycle(); cycle(); cycle();
    chk("bp_idle_after_drain", 32'(res_valid), 32'd0);

    // Throughput: 32 back-to-back, one result per cycle after the pipeline fills.
    res_ready = 1'b1; ir_drop = 1'b0; first = -1; last = -1; nres = 0;
    for (int c = 0; c < 45; c++) begin
      if (c < 32) begin
        if (!in_ready) ir_drop = 1'b1;
        in_valid = 1'b1; in_cmd = c[0]; in_addr = 8'(c); in_data = 8'(c);
      end else begin
        in_valid = 1'b0;
      end
      cycle();
      if (res_valid) begin
        if (first < 0) first = c;
        last = c;
        nres++;
      end
    end
    chk("tp_in_ready_steady", 32'(ir_drop), 32'd0);
    chk("tp_count", 32'(nres), 32'd32);
    chk("tp_first_latency", 32'(first), 32'd3);
    chk("tp_consecutive", 32'(last - first + 1), 32'd32);
    chk("tp_sb_empty", 32'(exp_q.size()), 32'd0);

    // Random stimulus with 50% result backpressure.
    start_tx = n_tx; max_res = 0;
    in_valid = 1'b1; in_cmd = 1'($urandom); in_addr = 8'($urandom); in_data = 8'($urandom);
    for (int c = 0; c < 20000 && (n_tx - start_tx) < 1000; c++) begin
      res_ready = 1'($urandom_range(0, 1));
      acc = in_valid && in_ready;
      cycle();
      if (int'(dut.res_cnt_q) > max_res) max_res = int'(dut.res_cnt_q);
      if (acc || !in_valid) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_cmd = 1'($urandom); in_addr = 8'($urandom); in_data = 8'($urandom);
      end
    end
    in_valid = 1'b0; res_ready = 1'b1;
    chk("rand_accepted", 32'(n_tx - start_tx), 32'd1000);
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) cycle();
    chk("rand_drained", 32'(exp_q.size()), 32'd0);
    chk("rand_res_cnt_bound", 32'(max_res <= 4), 32'd1);

    // Reset with work queued and in flight.
    res_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1; in_cmd = c[0]; in_addr = 8'hC0 + 8'(c); in_data = 8'(c * 7);
      cycle();
    end
    in_valid = 1'b0;
    cycle(); cycle();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
    res_ready = 1'b1; seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      cycle();
      if (res_valid) seen = 1'b1;
    end
    chk("mid_rst_no_stale", 32'(seen), 32'd0);
    latency_op("post_rst", 1'b0, 8'h99, 8'h0F, 8'h10);
    chk("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
Front-end issue/return stage for the 8-bit increment/decrement ALU stage (cmd=0: dout=data+1; cmd=1: dout=data-1; registered, 1-cycle latency, no valid/addr tracking).
- Buffers incoming {cmd, addr, data} transactions behind a valid/ready handshake.
- Drives the ALU inputs with registered values.
- Captures alu_dout the cycle after it is valid, tags it with the originating addr/cmd, and presents it in order on a valid/ready result port.
- Credit logic guarantees no ALU result is ever dropped, since the ALU cannot stall.

Parameters:
CMD_DEPTH, 8, command FIFO entries (power of 2, >=2)
RES_DEPTH, 4, result FIFO entries = issue credits (power of 2, >=4 for full throughput)

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  reset
in_valid  in  1  producer has a transaction
in_ready  out  1  command FIFO can accept
in_cmd  in  1  0=increment, 1=decrement
in_addr  in  8  tag carried to result
in_data  in  8  operand
alu_cmd  out  1  to ALU cmd (registered)
alu_addr  out  8  to ALU addr (registered)
alu_data  out  8  to ALU data (registered)
alu_dout  in  8  ALU registered result
res_valid  out  1  result FIFO non-empty
res_ready  in  1  consumer accepts result
res_cmd  out  1  cmd of head result
res_addr  out  8  addr of head result
res_data  out  8  captured alu_dout of head result

Behaviour:
- Reset: rst, synchronous, active-low; clock clk. Shares rst with the ALU stage.
- While rst=0 at a posedge:
  - Flush both FIFOs, clear s1/s2 valid flags.
  - alu_cmd/alu_addr/alu_data <= 0.
  - Outputs after reset: in_ready=1, res_valid=0, res_* = 0.
  - Reset mid-operation discards every queued and in-flight transaction; nothing from before reset may appear on res_*.
- Command FIFO:
  - in_ready = (cmd_count != CMD_DEPTH), from registered count.
  - Push on in_valid && in_ready.
  - No bypass: an entry pushed at edge t is issuable at edge t+1 at the earliest.
- Issue condition, evaluated each cycle: cmd_count != 0 && (s1 + s2 + res_count) < RES_DEPTH, using registered occupancies.
  - A result popped in the same cycle does not return its credit until the next cycle (conservative, no comb path res_ready->issue).
- Pipeline:
  - Issue at edge t: pop FIFO head into alu_* regs; set s1=1 with {cmd,addr} shadow.
  - Edge t+1: ALU registers dout; s2 <= s1, shadow moves to stage 2.
  - Edge t+2: if s2, push {cmd, addr, alu_dout} into result FIFO.
- alu_* hold their last value when not issuing. The ALU output during idle cycles is ignored because s1/s2 gate capture.
- Result FIFO:
  - res_valid = (res_count != 0).
  - res_* show the head entry combinationally from storage.
  - Pop on res_valid && res_ready.
  - Simultaneous push and pop is legal at any occupancy, count unchanged.
  - Overflow is impossible by credit rule (assertion: push never when res_count==RES_DEPTH without pop).
- Latency: push accepted at edge t0 -> res_valid high after edge t0+3 (empty system).
- Throughput: 1 result/cycle with res_ready held 1 and RES_DEPTH>=4 (steady state s1=s2=1, res_count<=1).
- Ordering: strict FIFO order end to end.
- Arithmetic is done in the ALU only; this block never modifies data. Wrap-around (8'hFF+1=8'h00, 8'h00-1=8'hFF) must pass through unmodified.
- Pointers wrap modulo depth; counts are log2(depth)+1 bits.

Test Plan:
- Single op: after reset, push cmd=0 addr=8'h10 data=8'h41 at edge 0, res_ready=1 -> res_valid=1 after edge 3 only, res_data=8'h42, res_addr=8'h10, res_cmd=0; res_valid=0 next cycle.
- Wrap: push {cmd=1,data=8'h00,addr=1} then {cmd=0,data=8'hFF,addr=2} -> results in order 8'hFF/addr 1, then 8'h00/addr 2.
- Backpressure/full: res_ready=0, in_valid held with 14 distinct txns -> exactly 4 issued; in_ready drops to 0 after 12 accepted (8 in cmd FIFO). Then res_ready=1 -> all 12 returned in order, correct data, no loss or duplication.
- Throughput: res_ready=1, 32 back-to-back pushes (data=i, cmd=i[0]) -> 32 results on consecutive cycles after initial latency, in_ready never drops.
- Random res_ready (50%) with random stimulus, 1000 txns -> scoreboard match on {cmd, addr, data±1}, res_count never exceeds 4.
- Reset mid-flight: 6 txns queued/in flight, assert rst=0 for one edge -> next cycle in_ready=1, res_valid=0; no pre-reset result ever appears; a new txn afterwards returns with 3-cycle latency.
